vga_scan_mixer: RTL

- Drives the pixel raster that every sprite layer (player, enemies, road objects) consumes.
- Generates the 640x480@60 hcount/vcount scan, produces hsync/vsync, and collects each layer's registered colour and "data" flag.
- Outputs the final 8-bit RGB332 pixel to the VGA DAC pins.
- Sits at the top of the video path, between the sprite layers and the board connector.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_scan_mixer_if.sv | 50 +++++
 rtl/vga_sync_counter.sv | 54 +++++
 rtl/vga_scan_mixer.sv | 97 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants for the VGA scan path: default 640x480@60 timing,
//   derived totals / sync windows, and the RGB332 colour packing.
//   Optional build macro used by this slice: TEST_PATTERN_EN (colour bars).
package vga_pkg;

    // Default horizontal timing, in pixels
    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
    localparam int H_SYNC_START = H_ACTIVE + H_FP;                   // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;             // 752

    // Default vertical timing, in lines
    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525
    localparam int V_SYNC_START = V_ACTIVE + V_FP;                   // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;             // 492

    // Counter width for hcount/vcount
    localparam int CNT_W = 10;

    // RGB332 field widths
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb332_t;

    // Colour-bar palette: bar index bits {2,1,0} switch red, green, blue
    // fully on, giving 00,03,1C,1F,E0,E3,FC,FF.
    function automatic rgb332_t bar_colour(input logic [2:0] bar);
        rgb332_t c;
        c.r = {R_W{bar[2]}};
        c.g = {G_W{bar[1]}};
        c.b = {B_W{bar[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_scan_mixer_if.sv
// vga_scan_mixer_if
//   Bundles the layer-side inputs and the raster/VGA outputs of the mixer.
//   master : layer / board side (drives colours, reads the scan position)
//   slave  : vga_scan_mixer
//   Signals: enable, layer_rgb[8*NUM_LAYERS], layer_data[NUM_LAYERS], bg_rgb,
//            hcount, vcount, pixel_tick, hsync, vsync, red, green, blue,
//            video_on, frame_start; test_mode only with TEST_PATTERN_EN.
interface vga_scan_mixer_if #(
    parameter int NUM_LAYERS = 4
);
    import vga_pkg::*;

`ifdef TEST_PATTERN_EN
    logic                      test_mode;
`endif
    logic                      enable;
    logic [RGB_W*NUM_LAYERS-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]     layer_data;
    logic [RGB_W-1:0]          bg_rgb;

    logic [CNT_W-1:0]          hcount;
    logic [CNT_W-1:0]          vcount;
    logic                      pixel_tick;
    logic                      hsync;
    logic                      vsync;
    logic [R_W-1:0]            red;
    logic [G_W-1:0]            green;
    logic [B_W-1:0]            blue;
    logic                      video_on;
    logic                      frame_start;

    modport master (
`ifdef TEST_PATTERN_EN
        output test_mode,
`endif
        output enable, layer_rgb, layer_data, bg_rgb,
        input  hcount, vcount, pixel_tick, hsync, vsync,
        input  red, green, blue, video_on, frame_start
    );

    modport slave (
`ifdef TEST_PATTERN_EN
        input  test_mode,
`endif
        input  enable, layer_rgb, layer_data, bg_rgb,
        output hcount, vcount, pixel_tick, hsync, vsync,
        output red, green, blue, video_on, frame_start
    );

endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter
//   Pixel-clock divider and raster position counters.
//   Ports: clock, reset_n (async, active low)
//          hcount/vcount : current scan position
//          pixel_tick    : high on the last system clock of each pixel
//          frame_start   : one clock high when (0,0) is first shown after a wrap
//   CLK_DIV must be >= 2: layers need a clock after hcount moves to respond.
module vga_sync_counter #(
    parameter int CLK_DIV = 2,
    parameter int H_TOT   = 800,
    parameter int V_TOT   = 525
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       pixel_tick,
    output logic       frame_start
);
    import vga_pkg::*;

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic          h_last;
    logic          v_last;

    assign pixel_tick = (div == DW'(CLK_DIV - 1));
    assign h_last     = (hcount == CNT_W'(H_TOT - 1));
    assign v_last     = (vcount == CNT_W'(V_TOT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            div <= pixel_tick ? '0 : div + 1'b1;
            // Registered so the pulse lines up with the clock that first
            // presents (0,0); it drops again on the following clock.
            frame_start <= pixel_tick && h_last && v_last;
            if (pixel_tick) begin
                if (h_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_scan_mixer.sv
// vga_scan_mixer
//   Top of the video path: raster generation, layer priority mixing and the
//   registered VGA output stage (RGB332, hsync, vsync, video_on).
//   Ports: clock, reset_n (async, active low)
//          bus (vga_scan_mixer_if.slave): enable, layer_rgb, layer_data, bg_rgb
//          in; hcount, vcount, pixel_tick, hsync, vsync, red, green, blue,
//          video_on, frame_start out.
//   Layer 0 has the highest priority; no blending.
//   Build macro TEST_PATTERN_EN adds bus.test_mode: 128-px colour bars
//   replace layers and background in the active area.
//   Outputs are registered on pixel_tick from the current hcount/vcount, so
//   they lag the scan position by one pixel.
module vga_scan_mixer #(
    parameter int   CLK_DIV    = 2,
    parameter int   NUM_LAYERS = 4,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP
) (
    input  logic              clock,
    input  logic              reset_n,
    vga_scan_mixer_if.slave   bus
);
    import vga_pkg::*;

    // Totals must fit the 10-bit counters (800/525 by default).
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    vga_sync_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOT   (H_TOT),
        .V_TOT   (V_TOT)
    ) u_sync_counter (
        .clock       (clock),
        .reset_n     (reset_n),
        .hcount      (bus.hcount),
        .vcount      (bus.vcount),
        .pixel_tick  (bus.pixel_tick),
        .frame_start (bus.frame_start)
    );

    logic    active;
    logic    hs_zone;
    logic    vs_zone;
    rgb332_t pick;

    assign active  = (bus.hcount < CNT_W'(H_ACTIVE)) && (bus.vcount < CNT_W'(V_ACTIVE));
    assign hs_zone = (bus.hcount >= CNT_W'(HS_START)) && (bus.hcount < CNT_W'(HS_END));
    assign vs_zone = (bus.vcount >= CNT_W'(VS_START)) && (bus.vcount < CNT_W'(VS_END));

    // Walk from the lowest priority upward so the lowest index set wins.
    always_comb begin
        pick = rgb332_t'(bus.bg_rgb);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (bus.layer_data[i])
                pick = rgb332_t'(bus.layer_rgb[RGB_W*i +: RGB_W]);
        end
`ifdef TEST_PATTERN_EN
        if (bus.test_mode)
            pick = bar_colour(bus.hcount[9:7]);
`endif
        // Blanking and video disable both black out the pins; layers that
        // still flag data outside the active area are ignored here.
        if (!active || !bus.enable)
            pick = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.red      <= '0;
            bus.green    <= '0;
            bus.blue     <= '0;
            bus.video_on <= 1'b0;
            bus.hsync    <= ~SYNC_POL;
            bus.vsync    <= ~SYNC_POL;
        end else if (bus.pixel_tick) begin
            bus.red      <= pick.r;
            bus.green    <= pick.g;
            bus.blue     <= pick.b;
            bus.video_on <= active;
            bus.hsync    <= hs_zone ? SYNC_POL : ~SYNC_POL;
            bus.vsync    <= vs_zone ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
